// File: rtl/reorder_buffer_if.sv
// Bus bundle between the reorder buffer and the issue unit, CDB and register file.
// The master side is the issue/CDB/regfile environment; the slave side is the ROB.
interface rob_if #(
    parameter int IDX_W = 6
);
    logic             rdy;

    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic             issue_is_br;
    logic             issue_is_st;
    logic [IDX_W-1:0] issue_tag;
    logic             rob_full;

    logic             cdb_valid;
    logic [IDX_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             cdb_mispred;
    logic [31:0]      cdb_pc;

    logic [IDX_W-1:0] q1_tag;
    logic [IDX_W-1:0] q2_tag;
    logic             q1_ready;
    logic             q2_ready;
    logic [31:0]      q1_value;
    logic [31:0]      q2_value;

    logic             commit_valid;
    logic [IDX_W-1:0] commit_tag;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_value;
    logic             commit_store;
    logic             flush;
    logic [31:0]      flush_pc;

    modport master (
        output rdy, issue_valid, issue_rd, issue_is_br, issue_is_st,
               cdb_valid, cdb_tag, cdb_value, cdb_mispred, cdb_pc, q1_tag, q2_tag,
        input  issue_tag, rob_full, q1_ready, q2_ready, q1_value, q2_value,
               commit_valid, commit_tag, commit_rd, commit_value, commit_store,
               flush, flush_pc
    );

    modport slave (
        input  rdy, issue_valid, issue_rd, issue_is_br, issue_is_st,
               cdb_valid, cdb_tag, cdb_value, cdb_mispred, cdb_pc, q1_tag, q2_tag,
        output issue_tag, rob_full, q1_ready, q2_ready, q1_value, q2_value,
               commit_valid, commit_tag, commit_rd, commit_value, commit_store,
               flush, flush_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates rename tags at issue, captures CDB
// results, retires one entry per cycle from the head and raises a one-cycle flush
// when a mispredicted branch reaches retirement.
module reorder_buffer #(
    parameter int IDX_W = 6
) (
    input  logic  clk,
    input  logic  rst,
    rob_if.slave  bus
);
    localparam int              DEPTH      = 1 << IDX_W;
    localparam logic [IDX_W:0]  FULL_COUNT = (IDX_W+1)'(DEPTH);

    // Pointers and occupancy
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;

    // Per-entry status bits (reset) and payload (no reset, qualified by busy)
    logic [DEPTH-1:0] busy_q, ready_q, mispred_q;
    logic [4:0]       rd_q    [DEPTH];
    logic             is_br_q [DEPTH];
    logic             is_st_q [DEPTH];
    logic [31:0]      value_q [DEPTH];
    logic [31:0]      pc_q    [DEPTH];

    // Registered retire/flush outputs
    logic             commit_valid_q, commit_valid_d;
    logic             commit_store_q, commit_store_d;
    logic [IDX_W-1:0] commit_tag_q, commit_tag_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [31:0]      commit_value_q, commit_value_d;
    logic             flush_q, flush_d;
    logic [31:0]      flush_pc_q, flush_pc_d;

    logic full;
    logic do_retire, do_flush, do_issue, do_wb;
    logic q1_fwd, q2_fwd;

    // Event qualification: rdy low freezes everything; the flush cycle and the
    // flushing edge itself swallow issue and CDB traffic.
    always_comb begin
        full      = (count_q == FULL_COUNT);
        do_retire = bus.rdy && busy_q[head_q] && ready_q[head_q];
        do_flush  = do_retire && mispred_q[head_q];
        do_issue  = bus.rdy && bus.issue_valid && !full && !flush_q && !do_flush;
        do_wb     = bus.rdy && bus.cdb_valid && busy_q[bus.cdb_tag] && !flush_q && !do_flush;
    end

    // Next-state for pointers, count and the registered commit/flush outputs
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = 1'b0;
        commit_store_d = 1'b0;
        commit_tag_d   = commit_tag_q;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        flush_d        = 1'b0;
        flush_pc_d     = flush_pc_q;

        if (do_retire) begin
            // A branch without a destination never writes the register file
            commit_valid_d = (rd_q[head_q] != 5'd0) && !is_st_q[head_q]
                             && !(is_br_q[head_q] && rd_q[head_q] == 5'd0);
            commit_store_d = is_st_q[head_q];
            commit_tag_d   = head_q;
            commit_rd_d    = rd_q[head_q];
            commit_value_d = value_q[head_q];
        end

        if (do_flush) begin
            flush_d    = 1'b1;
            flush_pc_d = pc_q[head_q];
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (do_issue)  tail_d = tail_q + 1'b1;
            if (do_retire) head_d = head_q + 1'b1;
            count_d = count_q + {{IDX_W{1'b0}}, do_issue} - {{IDX_W{1'b0}}, do_retire};
        end
    end

    // Pointer, count and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_store_q <= 1'b0;
            commit_tag_q   <= '0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_store_q <= commit_store_d;
            commit_tag_q   <= commit_tag_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    // Entry status bits: allocate at tail, mark ready on CDB, free at head
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            ready_q   <= '0;
            mispred_q <= '0;
        end else if (do_flush) begin
            busy_q    <= '0;
            ready_q   <= '0;
            mispred_q <= '0;
        end else begin
            if (do_wb) begin
                ready_q[bus.cdb_tag]   <= 1'b1;
                mispred_q[bus.cdb_tag] <= bus.cdb_mispred;
            end
            if (do_issue) begin
                busy_q[tail_q]    <= 1'b1;
                ready_q[tail_q]   <= 1'b0;
                mispred_q[tail_q] <= 1'b0;
            end
            if (do_retire) begin
                busy_q[head_q] <= 1'b0;
            end
        end
    end

    // Entry payload: static fields at issue, result fields at writeback
    always_ff @(posedge clk) begin
        if (do_issue) begin
            rd_q[tail_q]    <= bus.issue_rd;
            is_br_q[tail_q] <= bus.issue_is_br;
            is_st_q[tail_q] <= bus.issue_is_st;
        end
        if (do_wb) begin
            value_q[bus.cdb_tag] <= bus.cdb_value;
            pc_q[bus.cdb_tag]    <= bus.cdb_pc;
        end
    end

    // Operand lookups with same-cycle CDB forwarding taking priority
    always_comb begin
        q1_fwd       = bus.cdb_valid && (bus.cdb_tag == bus.q1_tag);
        q2_fwd       = bus.cdb_valid && (bus.cdb_tag == bus.q2_tag);
        bus.q1_ready = q1_fwd || (busy_q[bus.q1_tag] && ready_q[bus.q1_tag]);
        bus.q2_ready = q2_fwd || (busy_q[bus.q2_tag] && ready_q[bus.q2_tag]);
        bus.q1_value = q1_fwd ? bus.cdb_value : value_q[bus.q1_tag];
        bus.q2_value = q2_fwd ? bus.cdb_value : value_q[bus.q2_tag];
    end

    assign bus.issue_tag    = tail_q;
    assign bus.rob_full     = full;
    assign bus.commit_valid = commit_valid_q && bus.rdy;
    assign bus.commit_store = commit_store_q && bus.rdy;
    assign bus.flush        = flush_q && bus.rdy;
    assign bus.commit_tag   = commit_tag_q;
    assign bus.commit_rd    = commit_rd_q;
    assign bus.commit_value = commit_value_q;
    assign bus.flush_pc     = flush_pc_q;
endmodule
